// File: rtl/cpu5_pipeline.sv
`default_nettype none
`timescale 1ns/1ps
// == cpu5_pipeline : 5-stage IF/ID/EX/MEM/WB core, forwarding, load-use stall, EX-resolved BEQ ==
// == optional WB trace via CPU5_TRACE_EN                                          rev 1.0 ==
module cpu5_pipeline #(
  parameter int ADDER_TYPE = 1
) (
  input logic clk,
  input logic reset
);
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h07;
  localparam logic [5:0] OP_LW   = 6'h08;
  localparam logic [5:0] OP_SW   = 6'h09;
  localparam logic [5:0] OP_BEQ  = 6'h0A;
  localparam logic [31:0] PC_MASK = 32'h0000_03FF;

  logic [31:0] imem    [0:255];
  logic [31:0] dmem    [0:255];
  logic [31:0] regfile [0:31];
  logic [31:0] pc;

  logic [31:0] ifid_instr;
  logic [9:0]  ifid_pc;
  logic [5:0]  idex_op;
  logic [4:0]  idex_rd, idex_rs1, idex_rs2;
  logic [31:0] idex_a, idex_b, idex_imm;
  logic [9:0]  idex_pc;
  logic [5:0]  exmem_op;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_res, exmem_store;
  logic        exmem_we;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;

  logic [5:0]  id_op;
  logic [4:0]  id_rd, id_rs1, id_src2;
  logic        id_use1, id_use2, stall;
  logic [31:0] id_a, id_b;

  always_comb begin
    id_op = ifid_instr[31:26];
    if (id_op > OP_BEQ) id_op = OP_NOP;
    id_rd   = ifid_instr[25:21];
    id_rs1  = ifid_instr[20:16];
    // BEQ compares against the register named in the rd field
    id_src2 = (id_op == OP_BEQ) ? id_rd : ifid_instr[15:11];
    id_use1 = (id_op != OP_NOP);
    id_use2 = ((id_op != OP_NOP) && (id_op <= OP_SLT)) || (id_op == OP_SW) || (id_op == OP_BEQ);
  end

  // memwb_we is only ever set for rd != 0, so the bypass never touches r0
  assign id_a = (memwb_we && memwb_rd == id_rs1)  ? memwb_data : regfile[id_rs1];
  assign id_b = (memwb_we && memwb_rd == id_src2) ? memwb_data : regfile[id_src2];

  assign stall = (idex_op == OP_LW) && (idex_rd != 5'd0) &&
                 ((id_use1 && id_rs1 == idex_rd) || (id_use2 && id_src2 == idex_rd));

  logic        exmem_fwd, ex_taken, ex_we, add_cin;
  logic [31:0] ex_a, ex_b, ex_res, ex_target, add_x, add_y, add_sum;

  assign exmem_fwd = exmem_we && (exmem_op != OP_LW);

  always_comb begin
    if (exmem_fwd && exmem_rd == idex_rs1)     ex_a = exmem_res;
    else if (memwb_we && memwb_rd == idex_rs1) ex_a = memwb_data;
    else                                       ex_a = idex_a;
    if (exmem_fwd && exmem_rd == idex_rs2)     ex_b = exmem_res;
    else if (memwb_we && memwb_rd == idex_rs2) ex_b = memwb_data;
    else                                       ex_b = idex_b;
  end

  always_comb begin
    add_x   = ex_a;
    add_y   = ex_b;
    add_cin = 1'b0;
    case (idex_op)
      OP_SUB, OP_SLT:        begin add_y = ~ex_b; add_cin = 1'b1; end
      OP_ADDI, OP_LW, OP_SW: add_y = idex_imm;
      default:               add_y = ex_b;
    endcase
  end

  generate
    if (ADDER_TYPE == 0) begin : g_ripple
      always_comb begin
        logic carry;
        carry   = add_cin;
        add_sum = '0;
        for (int i = 0; i < 32; i++) begin
          add_sum[i] = add_x[i] ^ add_y[i] ^ carry;
          carry      = (add_x[i] & add_y[i]) | (carry & (add_x[i] ^ add_y[i]));
        end
      end
    end else begin : g_cla
      always_comb begin
        logic       cblk;
        logic [3:0] g4, p4, bc;
        cblk    = add_cin;
        add_sum = '0;
        for (int k = 0; k < 8; k++) begin
          g4 = add_x[4*k +: 4] & add_y[4*k +: 4];
          p4 = add_x[4*k +: 4] ^ add_y[4*k +: 4];
          bc[0] = cblk;
          bc[1] = g4[0] | (p4[0] & cblk);
          bc[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cblk);
          bc[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & cblk);
          add_sum[4*k +: 4] = p4 ^ bc;
          cblk = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
                 (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & cblk);
        end
      end
    end
  endgenerate

  always_comb begin
    case (idex_op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW: ex_res = add_sum;
      OP_AND:  ex_res = ex_a & ex_b;
      OP_OR:   ex_res = ex_a | ex_b;
      OP_XOR:  ex_res = ex_a ^ ex_b;
      OP_SLT:  ex_res = {31'd0, ($signed(ex_a) < $signed(ex_b))};
      default: ex_res = '0;
    endcase
  end

  assign ex_taken  = (idex_op == OP_BEQ) && (ex_a == ex_b);
  assign ex_target = ({22'd0, idex_pc} + 32'd4 + {idex_imm[29:0], 2'b00}) & PC_MASK;
  assign ex_we     = (idex_op != OP_NOP) && (idex_op <= OP_LW) && (idex_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      ifid_instr  <= '0;
      ifid_pc     <= '0;
      idex_op     <= OP_NOP;
      idex_rd     <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_imm    <= '0;
      idex_pc     <= '0;
      exmem_op    <= OP_NOP;
      exmem_rd    <= '0;
      exmem_res   <= '0;
      exmem_store <= '0;
      exmem_we    <= 1'b0;
      memwb_we    <= 1'b0;
      memwb_rd    <= '0;
      memwb_data  <= '0;
    end else begin
      // a taken branch overrides a concurrent load-use stall
      if (ex_taken) begin
        pc         <= ex_target;
        ifid_instr <= '0;
        ifid_pc    <= '0;
      end else if (!stall) begin
        pc         <= (pc + 32'd4) & PC_MASK;
        ifid_instr <= imem[pc[9:2]];
        ifid_pc    <= pc[9:0];
      end
      if (ex_taken || stall) begin
        idex_op <= OP_NOP;
        idex_rd <= '0;
      end else begin
        idex_op  <= id_op;
        idex_rd  <= id_rd;
        idex_rs1 <= id_rs1;
        idex_rs2 <= id_src2;
        idex_a   <= id_a;
        idex_b   <= id_b;
        idex_imm <= {{16{ifid_instr[15]}}, ifid_instr[15:0]};
        idex_pc  <= ifid_pc;
      end
      exmem_op    <= idex_op;
      exmem_rd    <= idex_rd;
      exmem_res   <= ex_res;
      exmem_store <= ex_b;
      exmem_we    <= ex_we;
      memwb_we    <= exmem_we;
      memwb_rd    <= exmem_rd;
      memwb_data  <= (exmem_op == OP_LW) ? dmem[exmem_res[9:2]] : exmem_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (memwb_we) begin
      regfile[memwb_rd] <= memwb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && exmem_op == OP_SW) dmem[exmem_res[9:2]] <= exmem_store;
  end

`ifdef CPU5_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && memwb_we) $display("[%0t] WB r%0d = %h", $time, memwb_rd, memwb_data);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu5_pipeline.sv
`default_nettype none
`timescale 1ns/1ps
// == tb_cpu5_pipeline : scoreboard bench for cpu5_pipeline, both adder variants run in lockstep ==
// == rev 1.0                                                                                    ==
module tb_cpu5_pipeline;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu5_pipeline #(.ADDER_TYPE(1)) dut    (.clk(clk), .reset(reset));
  cpu5_pipeline #(.ADDER_TYPE(0)) dut_rc (.clk(clk), .reset(reset));

  typedef struct {
    logic        is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] prog [0:255];

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs1, input int rs2);
    return {op, rd[4:0], rs1[4:0], rs2[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rd, input int rs1, input logic [15:0] imm);
    return {op, rd[4:0], rs1[4:0], imm};
  endfunction

  function automatic void push(input logic is_mem, input int idx, input logic [31:0] val);
    exp_t e;
    e.is_mem = is_mem;
    e.idx    = idx;
    e.val    = val;
    sb.push_back(e);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  task automatic start_prog();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i]    = prog[i];
      dut_rc.imem[i] = prog[i];
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = ri(6'h07, 1, 0, 16'd1);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i]    = prog[i];
      dut_rc.imem[i] = prog[i];
    end
    edges(2);
    tests_run++;
    if (dut.pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'd0);
    end
    for (int i = 0; i < 32; i += 7) begin
      tests_run++;
      if (dut.regfile[i] !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_reg r%0d: got %h expected %h", i, dut.regfile[i], 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    edges(1);
    tests_run++;
    if (dut.pc !== 32'd4) begin
      tests_failed++;
      $display("FAIL first_fetch_pc: got %h expected %h", dut.pc, 32'd4);
    end
  endtask

  task automatic test_back_to_back();
    clear_prog();
    prog[0] = ri(6'h07, 1, 0, 16'd5);
    prog[1] = ri(6'h07, 2, 0, 16'd7);
    prog[2] = rr(6'h01, 3, 1, 2);
    push(1'b0, 1, 32'd5);
    push(1'b0, 2, 32'd7);
    push(1'b0, 3, 32'd12);
    start_prog();
    edges(6);
    tests_run++;
    if (dut.regfile[3] !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_early r3: got %h expected %h", dut.regfile[3], 32'd0);
    end
    edges(1);
    tests_run++;
    if (dut.regfile[3] !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_no_stall r3: got %h expected %h", dut.regfile[3], 32'd12);
    end
    edges(4);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      tests_run++;
      if (dut.regfile[e.idx] !== e.val) begin
        tests_failed++;
        $display("FAIL b2b r%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] exp_rf [0:31];
    clear_prog();
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    prog[0]  = ri(6'h07, 1, 0, 16'd5);
    prog[1]  = ri(6'h07, 2, 0, 16'd7);
    prog[2]  = rr(6'h01, 3, 1, 2);
    prog[3]  = rr(6'h02, 4, 1, 2);
    prog[4]  = rr(6'h06, 5, 1, 2);
    prog[5]  = rr(6'h06, 11, 2, 1);
    prog[6]  = rr(6'h05, 12, 1, 2);
    prog[7]  = rr(6'h03, 13, 1, 2);
    prog[8]  = rr(6'h04, 14, 1, 2);
    prog[9]  = ri(6'h07, 15, 0, 16'hFFFF);
    prog[10] = rr(6'h01, 16, 15, 1);
    prog[11] = ri(6'h07, 0, 0, 16'd9);
    prog[12] = rr(6'h3F, 17, 1, 2);
    prog[13] = rr(6'h06, 18, 15, 1);
    exp_rf[1]  = 32'd5;
    exp_rf[2]  = 32'd7;
    exp_rf[3]  = 32'd12;
    exp_rf[4]  = 32'hFFFF_FFFE;
    exp_rf[5]  = 32'd1;
    exp_rf[12] = 32'd2;
    exp_rf[13] = 32'd5;
    exp_rf[14] = 32'd7;
    exp_rf[15] = 32'hFFFF_FFFF;
    exp_rf[16] = 32'd4;
    exp_rf[18] = 32'd1;
    for (int i = 0; i < 32; i++) push(1'b0, i, exp_rf[i]);
    start_prog();
    edges(22);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      tests_run++;
      if (dut.regfile[e.idx] !== e.val) begin
        tests_failed++;
        $display("FAIL arith_cla r%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
      end
      tests_run++;
      if (dut_rc.regfile[e.idx] !== e.val) begin
        tests_failed++;
        $display("FAIL arith_ripple r%0d: got %h expected %h", e.idx, dut_rc.regfile[e.idx], e.val);
      end
    end
  endtask

  task automatic test_load_use();
    clear_prog();
    prog[0] = ri(6'h07, 3, 0, 16'd12);
    prog[1] = ri(6'h09, 0, 0, 16'h1800);
    prog[2] = ri(6'h08, 6, 0, 16'd0);
    prog[3] = rr(6'h01, 7, 6, 6);
    push(1'b1, 0, 32'd12);
    push(1'b0, 3, 32'd12);
    push(1'b0, 6, 32'd12);
    push(1'b0, 7, 32'd24);
    start_prog();
    edges(8);
    tests_run++;
    if (dut.regfile[7] !== 32'd0) begin
      tests_failed++;
      $display("FAIL load_use_early r7: got %h expected %h", dut.regfile[7], 32'd0);
    end
    edges(1);
    tests_run++;
    if (dut.regfile[7] !== 32'd24) begin
      tests_failed++;
      $display("FAIL load_use_one_stall r7: got %h expected %h", dut.regfile[7], 32'd24);
    end
    edges(4);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = e.is_mem ? dut.dmem[e.idx] : dut.regfile[e.idx];
      tests_run++;
      if (got !== e.val) begin
        tests_failed++;
        $display("FAIL load_use %s%0d: got %h expected %h", e.is_mem ? "dmem" : "r", e.idx, got, e.val);
      end
    end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = ri(6'h07, 1, 0, 16'd5);
    prog[1] = ri(6'h0A, 1, 1, 16'd2);
    prog[2] = ri(6'h07, 8, 0, 16'd1);
    prog[3] = ri(6'h07, 9, 0, 16'd1);
    prog[4] = ri(6'h07, 10, 0, 16'd3);
    prog[5] = ri(6'h0A, 1, 0, 16'd2);
    prog[6] = ri(6'h07, 11, 0, 16'd1);
    push(1'b0, 1, 32'd5);
    push(1'b0, 8, 32'd0);
    push(1'b0, 9, 32'd0);
    push(1'b0, 10, 32'd3);
    push(1'b0, 11, 32'd1);
    start_prog();
    edges(8);
    tests_run++;
    if (dut.regfile[10] !== 32'd0) begin
      tests_failed++;
      $display("FAIL branch_early r10: got %h expected %h", dut.regfile[10], 32'd0);
    end
    edges(1);
    tests_run++;
    if (dut.regfile[10] !== 32'd3) begin
      tests_failed++;
      $display("FAIL branch_target r10: got %h expected %h", dut.regfile[10], 32'd3);
    end
    edges(6);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      tests_run++;
      if (dut.regfile[e.idx] !== e.val) begin
        tests_failed++;
        $display("FAIL branch r%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    prog[0] = ri(6'h07, 3, 0, 16'd99);
    prog[5] = ri(6'h07, 4, 0, 16'd77);
    prog[6] = ri(6'h09, 0, 0, 16'h2000);
    start_prog();
    edges(9);
    tests_run++;
    if (dut.regfile[3] !== 32'd99) begin
      tests_failed++;
      $display("FAIL midrun_pre r3: got %h expected %h", dut.regfile[3], 32'd99);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (dut.pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrun_async_pc: got %h expected %h", dut.pc, 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (dut.regfile[i] !== 32'd0) begin
        tests_failed++;
        $display("FAIL midrun_async r%0d: got %h expected %h", i, dut.regfile[i], 32'd0);
      end
    end
    edges(2);
    push(1'b1, 0, 32'd12);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      tests_run++;
      if (dut.dmem[e.idx] !== e.val) begin
        tests_failed++;
        $display("FAIL midrun_dmem_kept dmem%0d: got %h expected %h", e.idx, dut.dmem[e.idx], e.val);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    edges(1);
    tests_run++;
    if (dut.pc !== 32'd4) begin
      tests_failed++;
      $display("FAIL midrun_restart_pc: got %h expected %h", dut.pc, 32'd4);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_load_use();
    test_branch();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
